opto_emiperiod_gen: RTL and testbench
=====================================

OPTO_EMIPERIOD_GEN -- requirements
Module: opto_emiperiod_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning period counter width.
REQ-002 SHALL have parameter LEAD_W, default 8, meaning TDC start-ready lead width.
REQ-003 SHALL have parameter CH_NUM, default 4, meaning number of round-robin emitter channels (>=1).
REQ-004 SHALL have parameter DEF_PERIOD, default 125, meaning reset period in clocks (800 kHz at 10 ns).
REQ-005 SHALL have parameter DEF_LEAD, default 10, meaning reset lead in clocks.
REQ-006 SHALL have port i_clk, in, 1, the single clock.
REQ-007 SHALL have port i_rst, in, 1, reset; synchronous, active-high.
REQ-008 SHALL have port i_sync_ready, in, 1, run enable level.
REQ-009 SHALL have port i_cfg_valid, in, 1, one-cycle strobe; captures i_period_cfg and i_lead_cfg.
REQ-010 SHALL have port i_period_cfg, in, CNT_W, requested period P in clocks.
REQ-011 SHALL have port i_lead_cfg, in, LEAD_W, requested lead L in clocks.
REQ-012 SHALL have port i_burst_len, in, 16, pulses per run; 0 means continuous; sampled on IDLE->RUN.
REQ-013 SHALL have port o_angle_sync, out, 1, one-cycle emission/angle strobe.
REQ-014 SHALL have port o_tdc_strdy, out, 1, one-cycle TDC start-ready strobe, L cycles before o_angle_sync.
REQ-015 SHALL have port o_ch_sel, out, clog2(CH_NUM) (min 1), channel owning the current period.
REQ-016 SHALL have port o_busy, out, 1, high in RUN.
REQ-017 SHALL have port o_done, out, 1, one-cycle strobe when a burst completes.
REQ-018 SHALL have port o_cfg_err, out, 1, one-cycle strobe on rejected config.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE.
REQ-020 SHALL go IDLE->RUN at the edge sampling i_sync_ready=1; cnt<=0, pulse count<=0, burst length latched.
REQ-021 SHALL increment cnt each RUN cycle; at cnt==P-1 cnt<=0 and o_angle_sync<=1 for one cycle, giving period P exactly.
REQ-022 SHALL make the first o_angle_sync appear P cycles after the IDLE->RUN edge.
REQ-023 SHALL register o_tdc_strdy<=1 when cnt==P-1-L; L=0 makes it coincide with o_angle_sync.
REQ-024 SHALL advance o_ch_sel on each o_angle_sync, wrapping CH_NUM-1 -> 0; it resets to 0 on IDLE->RUN.
REQ-025 SHALL accept a config only if P>=2 and L<=P-1; otherwise it pulses o_cfg_err next cycle and keeps the active config.
REQ-026 SHALL hold an accepted config in a pending shadow, applied at the next wrap (cnt==P-1) or immediately in IDLE/DONE.
REQ-027 SHALL, when i_cfg_valid coincides with a wrap, apply the new config to the period starting at that wrap.
REQ-028 SHALL, on repeated i_cfg_valid before a wrap, keep only the last accepted value.
REQ-029 SHALL count pulses; with burst length N>0, the Nth o_angle_sync coincides with o_done and moves the block to DONE.
REQ-030 SHALL hold DONE until i_sync_ready=0, then go to IDLE; no pulses are issued in DONE.
REQ-031 SHALL, when i_sync_ready=0 in RUN, go to IDLE next edge with cnt=0, all strobes 0, no o_done, and in-flight pulses dropped.
REQ-032 SHALL keep the pulse counter saturating at 16'hFFFF in continuous mode (no wrap side effect).

Reset
REQ-033 SHALL, on i_rst=1 at an edge, set state IDLE, cnt=0, active and pending config = DEF_PERIOD/DEF_LEAD, and clear the pending flag.
REQ-034 SHALL reset outputs as o_angle_sync=0, o_tdc_strdy=0, o_ch_sel=0, o_busy=0, o_done=0, o_cfg_err=0.
REQ-035 SHALL let reset mid-RUN override all other inputs in that cycle.

Structure
REQ-036 SHALL place the state enum, MIN_PERIOD=2, and the default period/lead constants in package opto_emiperiod_pkg.
REQ-037 SHALL place validation plus the pending/active shadow registers in one sub-module, opto_emicfg_shadow; the counter/FSM stays in the top.

Verification
REQ-038 SHALL cover: defaults, i_sync_ready rises -> o_angle_sync at cycles 125, 250, 375; o_tdc_strdy at 115, 240; o_ch_sel 0,1,2,3,0.
REQ-039 SHALL cover: cfg P=50, L=5 mid-period -> current 125 period completes, then 50-cycle spacing, o_tdc_strdy 5 cycles earlier.
REQ-040 SHALL cover: cfg P=1 or P=20, L=20 -> o_cfg_err pulse, period stays 125.
REQ-041 SHALL cover: i_burst_len=3 -> exactly 3 pulses, o_done with the 3rd, o_busy low after; no restart until i_sync_ready toggles.
REQ-042 SHALL cover: i_sync_ready drop at cnt=60 -> IDLE next cycle, no strobes; re-raise -> first pulse 125 cycles later.
REQ-043 SHALL cover: i_rst asserted during RUN with pending cfg -> all outputs 0, defaults restored, pending discarded.

Source files
------------

// File: rtl/opto_emiperiod_pkg.sv
// Shared types and constants for the emitter period generator.
package opto_emiperiod_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } emi_state_e;

  localparam int MIN_PERIOD     = 2;
  localparam int EMI_DEF_PERIOD = 125;
  localparam int EMI_DEF_LEAD   = 10;
endpackage

// File: rtl/opto_emicfg_shadow.sv
// Period/lead config validation with a pending shadow that is promoted to
// the active config on i_apply (period wrap, or whenever not running).
module opto_emicfg_shadow
  import opto_emiperiod_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LEAD_W     = 8,
  parameter int DEF_PERIOD = EMI_DEF_PERIOD,
  parameter int DEF_LEAD   = EMI_DEF_LEAD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  input  logic [CNT_W-1:0]  i_period_cfg,
  input  logic [LEAD_W-1:0] i_lead_cfg,
  input  logic              i_apply,
  output logic [CNT_W-1:0]  o_period,
  output logic [LEAD_W-1:0] o_lead,
  output logic              o_cfg_err
);
  logic [CNT_W-1:0]  r_act_p, r_pend_p;
  logic [LEAD_W-1:0] r_act_l, r_pend_l;
  logic              r_pend_vld, r_cfg_err;
  logic              w_ok, w_acc;

  assign w_ok  = (i_period_cfg >= CNT_W'(MIN_PERIOD)) &&
                 (CNT_W'(i_lead_cfg) <= (i_period_cfg - CNT_W'(1)));
  assign w_acc = i_cfg_valid && w_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_act_p    <= CNT_W'(DEF_PERIOD);
      r_act_l    <= LEAD_W'(DEF_LEAD);
      r_pend_p   <= CNT_W'(DEF_PERIOD);
      r_pend_l   <= LEAD_W'(DEF_LEAD);
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= i_cfg_valid && !w_ok;
      if (w_acc) begin
        // A config landing on the apply cycle goes straight to active.
        r_pend_p <= i_period_cfg;
        r_pend_l <= i_lead_cfg;
        if (i_apply) begin
          r_act_p    <= i_period_cfg;
          r_act_l    <= i_lead_cfg;
          r_pend_vld <= 1'b0;
        end else begin
          r_pend_vld <= 1'b1;
        end
      end else if (i_apply && r_pend_vld) begin
        r_act_p    <= r_pend_p;
        r_act_l    <= r_pend_l;
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign o_period  = r_act_p;
  assign o_lead    = r_act_l;
  assign o_cfg_err = r_cfg_err;
endmodule

// File: rtl/opto_emiperiod_gen.sv
// Emitter period generator: angle-sync and TDC start-ready strobes with
// round-robin channel select, burst/continuous run control.
module opto_emiperiod_gen
  import opto_emiperiod_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LEAD_W     = 8,
  parameter int CH_NUM     = 4,
  parameter int DEF_PERIOD = 125,
  parameter int DEF_LEAD   = 10
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_sync_ready,
  input  logic                                     i_cfg_valid,
  input  logic [CNT_W-1:0]                         i_period_cfg,
  input  logic [LEAD_W-1:0]                        i_lead_cfg,
  input  logic [15:0]                              i_burst_len,
  output logic                                     o_angle_sync,
  output logic                                     o_tdc_strdy,
  output logic [((CH_NUM>1)?$clog2(CH_NUM):1)-1:0] o_ch_sel,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_cfg_err
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  emi_state_e        r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_pcnt, r_burst, w_pcnt_inc;
  logic [CH_W-1:0]   r_ch, w_ch_nx;
  logic              r_angle, r_tdc, r_done;
  logic [CNT_W-1:0]  w_period, w_tdc_pt;
  logic [LEAD_W-1:0] w_lead;
  logic              w_wrap, w_last, w_apply;

  opto_emicfg_shadow #(
    .CNT_W(CNT_W), .LEAD_W(LEAD_W), .DEF_PERIOD(DEF_PERIOD), .DEF_LEAD(DEF_LEAD)
  ) u_cfg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cfg_valid (i_cfg_valid),
    .i_period_cfg(i_period_cfg),
    .i_lead_cfg  (i_lead_cfg),
    .i_apply     (w_apply),
    .o_period    (w_period),
    .o_lead      (w_lead),
    .o_cfg_err   (o_cfg_err)
  );

  assign w_wrap     = (r_state == ST_RUN) && i_sync_ready && (r_cnt == w_period - CNT_W'(1));
  assign w_apply    = w_wrap || (r_state != ST_RUN);
  assign w_tdc_pt   = w_period - CNT_W'(1) - CNT_W'(w_lead);
  assign w_pcnt_inc = (r_pcnt == 16'hFFFF) ? r_pcnt : r_pcnt + 16'd1;
  assign w_last     = w_wrap && (r_burst != 16'd0) && (w_pcnt_inc == r_burst);
  assign w_ch_nx    = (r_ch == CH_W'(CH_NUM - 1)) ? '0 : r_ch + CH_W'(1);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (i_sync_ready) w_state_nx = ST_RUN;
      ST_RUN: begin
        if (!i_sync_ready) w_state_nx = ST_IDLE;
        else if (w_last)   w_state_nx = ST_DONE;
      end
      ST_DONE: if (!i_sync_ready) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_burst <= '0;
      r_ch    <= '0;
      r_angle <= 1'b0;
      r_tdc   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_angle <= 1'b0;
      r_tdc   <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_sync_ready) begin
            r_pcnt  <= '0;
            r_burst <= i_burst_len;
            r_ch    <= '0;
          end
        end
        ST_RUN: begin
          if (!i_sync_ready) begin
            r_cnt <= '0;
          end else begin
            if (w_wrap) begin
              r_cnt   <= '0;
              r_angle <= 1'b1;
              r_pcnt  <= w_pcnt_inc;
              r_ch    <= w_ch_nx;
              r_done  <= w_last;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            // Lead of 0 lands on the wrap point, so both strobes coincide.
            if (r_cnt == w_tdc_pt) r_tdc <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_angle_sync = r_angle;
  assign o_tdc_strdy  = r_tdc;
  assign o_ch_sel     = r_ch;
  assign o_busy       = (r_state == ST_RUN);
  assign o_done       = r_done;
endmodule

// File: tb/tb_opto_emiperiod_gen.sv
// Directed bench for opto_emiperiod_gen: strobe timing, config shadowing,
// burst/stop/reset behaviour against hand-computed cycle numbers.
module tb_opto_emiperiod_gen;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_sync_ready = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic [15:0] i_period_cfg = '0;
  logic [7:0]  i_lead_cfg = '0;
  logic [15:0] i_burst_len = '0;
  logic        o_angle_sync, o_tdc_strdy, o_busy, o_done, o_cfg_err;
  logic [1:0]  o_ch_sel;

  opto_emiperiod_gen dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sync_ready(i_sync_ready),
    .i_cfg_valid(i_cfg_valid), .i_period_cfg(i_period_cfg), .i_lead_cfg(i_lead_cfg),
    .i_burst_len(i_burst_len), .o_angle_sync(o_angle_sync), .o_tdc_strdy(o_tdc_strdy),
    .o_ch_sel(o_ch_sel), .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0;
  int na, nt, nd, ne, done_t;
  int ang_t [16];
  int ang_ch[16];
  int tdc_t [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    na = 0; nt = 0; nd = 0; ne = 0; done_t = -1;
    for (int i = 0; i < 16; i++) begin
      ang_t[i] = -1; ang_ch[i] = -1; tdc_t[i] = -1;
    end
  endtask

  // Advance to the next falling edge and log strobes relative to t0.
  task automatic step();
    @(negedge i_clk);
    cyc++;
    if (o_angle_sync) begin
      if (na < 16) begin ang_t[na] = cyc - t0; ang_ch[na] = int'(o_ch_sel); end
      na++;
    end
    if (o_tdc_strdy) begin
      if (nt < 16) tdc_t[nt] = cyc - t0;
      nt++;
    end
    if (o_done) begin done_t = cyc - t0; nd++; end
    if (o_cfg_err) ne++;
  endtask

  task automatic run_to(input int rel);
    while (cyc - t0 < rel) step();
  endtask

  task automatic start_run();
    clear();
    i_sync_ready = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic stop_run();
    i_sync_ready = 1'b0;
    step(); step();
  endtask

  task automatic send_cfg(input logic [15:0] p, input logic [7:0] l);
    i_cfg_valid = 1'b1; i_period_cfg = p; i_lead_cfg = l;
    step();
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    clear();
    // Reset state
    step(); step(); step();
    chk("rst_angle", o_angle_sync, 0);
    chk("rst_tdc",   o_tdc_strdy, 0);
    chk("rst_ch",    o_ch_sel, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_err",   o_cfg_err, 0);
    i_rst = 1'b0;
    step();

    // Default period/lead, continuous
    start_run();
    step();
    chk("t1_busy", o_busy, 1);
    chk("t1_ch0",  o_ch_sel, 0);
    run_to(510);
    chk("t1_ang0", ang_t[0], 125);
    chk("t1_ang1", ang_t[1], 250);
    chk("t1_ang2", ang_t[2], 375);
    chk("t1_ang3", ang_t[3], 500);
    chk("t1_tdc0", tdc_t[0], 115);
    chk("t1_tdc1", tdc_t[1], 240);
    chk("t1_ch_a", ang_ch[0], 1);
    chk("t1_ch_b", ang_ch[1], 2);
    chk("t1_ch_c", ang_ch[2], 3);
    chk("t1_ch_d", ang_ch[3], 0);
    chk("t1_nd",   nd, 0);
    stop_run();

    // Mid-period reconfig takes effect at the next wrap
    start_run();
    run_to(60);
    send_cfg(16'd50, 8'd5);
    run_to(240);
    chk("t2_ang0", ang_t[0], 125);
    chk("t2_ang1", ang_t[1], 175);
    chk("t2_ang2", ang_t[2], 225);
    chk("t2_tdc0", tdc_t[0], 115);
    chk("t2_tdc1", tdc_t[1], 170);
    chk("t2_tdc2", tdc_t[2], 220);
    chk("t2_ne",   ne, 0);
    stop_run();
    send_cfg(16'd125, 8'd10);

    // Rejected configs leave the period unchanged
    start_run();
    run_to(30);
    send_cfg(16'd1, 8'd0);
    chk("t3_err1", o_cfg_err, 1);
    step();
    chk("t3_err1_lo", o_cfg_err, 0);
    run_to(40);
    send_cfg(16'd20, 8'd20);
    chk("t3_err2", o_cfg_err, 1);
    run_to(260);
    chk("t3_ne",   ne, 2);
    chk("t3_ang0", ang_t[0], 125);
    chk("t3_ang1", ang_t[1], 250);
    stop_run();

    // Burst of 3
    i_burst_len = 16'd3;
    start_run();
    run_to(420);
    chk("t4_na",    na, 3);
    chk("t4_ang2",  ang_t[2], 375);
    chk("t4_nd",    nd, 1);
    chk("t4_donet", done_t, 375);
    chk("t4_busy",  o_busy, 0);
    run_to(600);
    chk("t4_hold_na", na, 3);
    chk("t4_hold_busy", o_busy, 0);
    i_burst_len = 16'd0;
    stop_run();

    // Stop at cnt=60, then restart
    start_run();
    run_to(60);
    i_sync_ready = 1'b0;
    step();
    chk("t5_busy", o_busy, 0);
    chk("t5_ang",  o_angle_sync, 0);
    chk("t5_tdc",  o_tdc_strdy, 0);
    run_to(260);
    chk("t5_na", na, 0);
    chk("t5_nt", nt, 0);
    chk("t5_nd", nd, 0);
    start_run();
    run_to(130);
    chk("t5_re_ang0", ang_t[0], 125);
    chk("t5_re_na",   na, 1);

    // Reset mid-run with a pending config
    run_to(140);
    send_cfg(16'd50, 8'd5);
    i_rst = 1'b1;
    i_cfg_valid = 1'b1; i_period_cfg = 16'd40; i_lead_cfg = 8'd3;
    step();
    chk("t6_ang",  o_angle_sync, 0);
    chk("t6_tdc",  o_tdc_strdy, 0);
    chk("t6_ch",   o_ch_sel, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_done, 0);
    chk("t6_err",  o_cfg_err, 0);
    i_rst = 1'b0;
    i_cfg_valid = 1'b0;
    start_run();
    run_to(260);
    chk("t6_ang0", ang_t[0], 125);
    chk("t6_ang1", ang_t[1], 250);
    chk("t6_tdc0", tdc_t[0], 115);
    chk("t6_ne",   ne, 0);
    stop_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
